// File: rtl/block_interleaver.sv
// Ping-pong ROWS x COLS block interleaver/deinterleaver on a serial bit stream.
// Define BLOCK_INTERLEAVER_FRAME_OUT_EN to add the parallel frame_out/frame_valid outputs.
module block_interleaver #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_sof
`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
  ,
  output logic [ROWS*COLS-1:0] frame_out,
  output logic                 frame_valid
`endif
);

  localparam int unsigned   N    = ROWS * COLS;
  localparam int unsigned   AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_FILLING  = 2'd1;
  localparam logic [1:0] S_FULL     = 2'd2;
  localparam logic [1:0] S_DRAINING = 2'd3;

  // Stored position of output bit j for the bank's latched mode.
  function automatic logic [AW-1:0] src_pos(input logic [AW-1:0] j, input logic m);
    int unsigned ji;
    int unsigned p;
    ji = 32'(j);
    if (m) p = (ji % COLS) * ROWS + ji / COLS;
    else   p = (ji % ROWS) * COLS + ji / ROWS;
    return AW'(p);
  endfunction

  logic [1:0][N-1:0] bank_q, bank_n;
  logic [1:0][1:0]   st_q, st_n;
  logic [1:0]        bmode_q, bmode_n;
  logic              wb_q, wb_n;
  logic [AW-1:0]     wc_q, wc_n;
  logic              fb_q, fb_n;
  logic [AW-1:0]     fc_q, fc_n;
  logic              ob_q, ob_n;
  logic              olast_q, olast_n;
  logic              in_ready_n, out_valid_n, out_bit_n, out_sof_n;
  logic              wr_fire, rd_fire, fetch_ok, load;

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  // Writer fill, bank state tracking and read-ahead into the output register.
  always_comb begin
    bank_n      = bank_q;
    st_n        = st_q;
    bmode_n     = bmode_q;
    wb_n        = wb_q;
    wc_n        = wc_q;
    fb_n        = fb_q;
    fc_n        = fc_q;
    ob_n        = ob_q;
    olast_n     = olast_q;
    out_valid_n = out_valid;
    out_bit_n   = out_bit;
    out_sof_n   = out_sof;
    fetch_ok    = 1'b0;
    load        = 1'b0;

    if (wr_fire) begin
      bank_n[wb_q][wc_q] = in_bit;
      if (wc_q == '0) begin
        st_n[wb_q]    = S_FILLING;
        bmode_n[wb_q] = mode;
      end
      if (wc_q == LAST) begin
        st_n[wb_q] = S_FULL;
        wc_n       = '0;
        wb_n       = ~wb_q;
      end else begin
        wc_n = wc_q + AW'(1);
      end
    end

    if (rd_fire) st_n[ob_q] = olast_q ? S_EMPTY : S_DRAINING;

    // Output bit 0 always maps to position 0, stored long before the bank completes,
    // so a bank completing this cycle can be fetched immediately.
    fetch_ok = (st_q[fb_q] == S_FULL) || (st_q[fb_q] == S_DRAINING) ||
               (wr_fire && (wb_q == fb_q) && (wc_q == LAST));
    load = fetch_ok && (!out_valid || out_ready);

    if (load) begin
      out_valid_n = 1'b1;
      out_bit_n   = bank_q[fb_q][src_pos(fc_q, bmode_q[fb_q])];
      out_sof_n   = (fc_q == '0);
      ob_n        = fb_q;
      olast_n     = (fc_q == LAST);
      if (fc_q == LAST) begin
        fc_n = '0;
        fb_n = ~fb_q;
      end else begin
        fc_n = fc_q + AW'(1);
      end
    end else if (rd_fire) begin
      out_valid_n = 1'b0;
      out_sof_n   = 1'b0;
    end

    in_ready_n = (st_n[wb_n] == S_EMPTY) || (st_n[wb_n] == S_FILLING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '0;
      st_q      <= {S_EMPTY, S_EMPTY};
      bmode_q   <= '0;
      wb_q      <= 1'b0;
      wc_q      <= '0;
      fb_q      <= 1'b0;
      fc_q      <= '0;
      ob_q      <= 1'b0;
      olast_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      bank_q    <= bank_n;
      st_q      <= st_n;
      bmode_q   <= bmode_n;
      wb_q      <= wb_n;
      wc_q      <= wc_n;
      fb_q      <= fb_n;
      fc_q      <= fc_n;
      ob_q      <= ob_n;
      olast_q   <= olast_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_bit   <= out_bit_n;
      out_sof   <= out_sof_n;
    end
  end

`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
  logic [N-1:0] frame_out_n;
  logic         frame_valid_n;

  // Permuted snapshot of a bank at the moment it becomes full.
  always_comb begin
    frame_out_n   = frame_out;
    frame_valid_n = 1'b0;
    if (wr_fire && (wc_q == LAST)) begin
      frame_valid_n = 1'b1;
      for (int unsigned j = 0; j < N; j++) begin
        frame_out_n[j] = bank_n[wb_q][src_pos(AW'(j), bmode_n[wb_q])];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_out   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_out   <= frame_out_n;
      frame_valid <= frame_valid_n;
    end
  end
`endif

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver: 2x4 and 3x5 instances against a matrix model.
module tb_block_interleaver;

  localparam int unsigned R  = 2;
  localparam int unsigned C  = 4;
  localparam int unsigned N  = R * C;
  localparam int unsigned R2 = 3;
  localparam int unsigned C2 = 5;
  localparam int unsigned N2 = R2 * C2;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mode, in_valid, in_ready, in_bit, out_valid, out_ready, out_bit, out_sof;
  logic b_mode, b_in_valid, b_in_ready, b_in_bit, b_out_valid, b_out_ready, b_out_bit, b_out_sof;
`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
  logic [N-1:0]  frame_out;
  logic          frame_valid;
  logic [N2-1:0] b_frame_out;
  logic          b_frame_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  block_interleaver #(.ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_sof(out_sof)
`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
    , .frame_out(frame_out), .frame_valid(frame_valid)
`endif
  );

  block_interleaver #(.ROWS(R2), .COLS(C2)) dut2 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bit(b_in_bit), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
    .out_sof(b_out_sof)
`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
    , .frame_out(b_frame_out), .frame_valid(b_frame_valid)
`endif
  );

  // Handshake logs: accepted inputs (with mode) and delivered outputs (with sof).
  bq_t acc_b, acc_m, got_b, got_s;
  bq_t acc2_b, acc2_m, got2_b, got2_s;

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin acc_b.push_back(in_bit); acc_m.push_back(mode); end
      if (out_valid && out_ready) begin got_b.push_back(out_bit); got_s.push_back(out_sof); end
      if (b_in_valid && b_in_ready) begin acc2_b.push_back(b_in_bit); acc2_m.push_back(b_mode); end
      if (b_out_valid && b_out_ready) begin got2_b.push_back(b_out_bit); got2_s.push_back(b_out_sof); end
    end
  end

  // Reference: interleave = write row-wise, read column-wise; deinterleave = write column-wise, read row-wise.
  task automatic model(input int rows, input int cols, input bq_t ib, input bq_t im,
                       output bq_t eb, output bq_t es);
    bit mat [16][16];
    int n;
    n  = rows * cols;
    eb = {};
    es = {};
    for (int f = 0; (f + 1) * n <= ib.size(); f++) begin
      if (im[f*n] == 1'b0) begin
        for (int k = 0; k < n; k++) mat[k / cols][k % cols] = ib[f*n + k];
        for (int c = 0; c < cols; c++)
          for (int r = 0; r < rows; r++) begin
            eb.push_back(mat[r][c]);
            es.push_back(c == 0 && r == 0);
          end
      end else begin
        for (int k = 0; k < n; k++) mat[k % rows][k / rows] = ib[f*n + k];
        for (int r = 0; r < rows; r++)
          for (int c = 0; c < cols; c++) begin
            eb.push_back(mat[r][c]);
            es.push_back(c == 0 && r == 0);
          end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_b = {}; acc_m = {}; got_b = {}; got_s = {};
    acc2_b = {}; acc2_m = {}; got2_b = {}; got2_s = {};
  endtask

  task automatic send_bit(input bit b, input bit m);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_bit   = b;
    mode     = m;
    while (in_ready !== 1'b1 && t < 500) begin tick(); t++; end
    if (t >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, t);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (got_b.size() < n && t < 2000) begin tick(); t++; end
    n_checks++;
    if (got_b.size() < n) begin
      n_fail++;
      $display("FAIL out_count: got %0d output bits, required %0d", got_b.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b0;
    repeat (3) tick();
    n_checks += 4;
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_bit !== 1'b0)   begin n_fail++; $display("FAIL rst_out_bit: got %b, required 0", out_bit); end
    if (out_sof !== 1'b0)   begin n_fail++; $display("FAIL rst_out_sof: got %b, required 0", out_sof); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
    clear_logs();
  endtask

  task automatic test_b5();
    logic [7:0] src, expv;
    src = 8'hB5;
    expv = 8'h9B;
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b5_early_valid: got %b, required 0", out_valid); end
      end
      send_bit(src[k], 1'b0);
    end
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b5_latency_valid: got %b, required 1", out_valid); end
    if (out_sof !== 1'b1)   begin n_fail++; $display("FAIL b5_first_sof: got %b, required 1", out_sof); end
    if (out_bit !== 1'b1)   begin n_fail++; $display("FAIL b5_first_bit: got %b, required 1", out_bit); end
    wait_outputs(8);
    for (int j = 0; j < 8 && j < got_b.size(); j++) begin
      n_checks += 2;
      if (got_b[j] !== expv[j]) begin n_fail++; $display("FAIL b5_bit j=%0d: got %b, required %b", j, got_b[j], expv[j]); end
      if (got_s[j] !== (j == 0)) begin n_fail++; $display("FAIL b5_sof j=%0d: got %b, required %b", j, got_s[j], (j == 0)); end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b5_idle_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_roundtrip();
    logic [7:0] il, orig;
    il   = 8'h9B;
    orig = 8'hB5;
    clear_logs();
    out_ready = 1'b1;
    // Mode only counts on bit 0; later mode values are noise.
    for (int k = 0; k < 8; k++) send_bit(il[k], (k == 0) ? 1'b1 : 1'($urandom));
    wait_outputs(8);
    for (int j = 0; j < 8 && j < got_b.size(); j++) begin
      n_checks++;
      if (got_b[j] !== orig[j]) begin n_fail++; $display("FAIL roundtrip j=%0d: got %b, required %b", j, got_b[j], orig[j]); end
    end
  endtask

  task automatic test_backpressure();
    bq_t eb, es;
    clear_logs();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_bit = 1'($urandom);
      mode   = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    model(R, C, acc_b, acc_m, eb, es);
    n_checks += 2;
    if (acc_b.size() != 16) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 16", acc_b.size()); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    for (int s = 0; s < 3 && eb.size() > 0; s++) begin
      n_checks += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid); end
      if (out_bit !== eb[0])  begin n_fail++; $display("FAIL bp_hold_bit: got %b, required %b", out_bit, eb[0]); end
      if (out_sof !== 1'b1)   begin n_fail++; $display("FAIL bp_hold_sof: got %b, required 1", out_sof); end
      tick();
    end
    out_ready = 1'b1;
    for (int h = 1; h <= 8; h++) begin
      tick();
      if (h >= 7) begin
        n_checks++;
        if (in_ready !== (h == 8)) begin
          n_fail++; $display("FAIL bp_release h=%0d: in_ready %b, required %b", h, in_ready, (h == 8));
        end
      end
    end
    wait_outputs(16);
    for (int j = 0; j < eb.size() && j < got_b.size(); j++) begin
      n_checks++;
      if (got_b[j] !== eb[j] || got_s[j] !== es[j]) begin
        n_fail++; $display("FAIL bp_data j=%0d: got %b/%b, required %b/%b", j, got_b[j], got_s[j], eb[j], es[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t eb, es;
    clear_logs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_bit = 1'($urandom);
      mode   = 1'($urandom);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready i=%0d: got %b, required 1", i, in_ready); end
      tick();
      if (i >= 7) begin
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid i=%0d: got %b, required 1", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_tail_valid i=%0d: got %b, required 1", i, out_valid); end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b, required 0", out_valid); end
    model(R, C, acc_b, acc_m, eb, es);
    n_checks++;
    if (got_b.size() != 24) begin n_fail++; $display("FAIL b2b_count: got %0d, required 24", got_b.size()); end
    for (int j = 0; j < eb.size() && j < got_b.size(); j++) begin
      n_checks++;
      if (got_b[j] !== eb[j] || got_s[j] !== es[j]) begin
        n_fail++; $display("FAIL b2b_data j=%0d: got %b/%b, required %b/%b", j, got_b[j], got_s[j], eb[j], es[j]);
      end
    end
  endtask

  task automatic test_random();
    bq_t eb, es;
    clear_logs();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_bit(1'($urandom), 1'($urandom));
        end
      end
      begin
        int t;
        t = 0;
        while (got_b.size() < 40 && t < 3000) begin
          out_ready = 1'($urandom);
          tick();
          t++;
        end
        out_ready = 1'b1;
      end
    join
    model(R, C, acc_b, acc_m, eb, es);
    n_checks++;
    if (got_b.size() != 40) begin n_fail++; $display("FAIL rand_count: got %0d, required 40", got_b.size()); end
    for (int j = 0; j < eb.size() && j < got_b.size(); j++) begin
      n_checks++;
      if (got_b[j] !== eb[j] || got_s[j] !== es[j]) begin
        n_fail++; $display("FAIL rand_data j=%0d: got %b/%b, required %b/%b", j, got_b[j], got_s[j], eb[j], es[j]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t eb, es;
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0);
    rst = 1'b1;
    tick();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle i=%0d: got %b, required 0", i, out_valid); end
    end
    for (int k = 0; k < 8; k++) send_bit(1'($urandom), (k == 0) ? 1'($urandom) : 1'b0);
    wait_outputs(8);
    model(R, C, acc_b, acc_m, eb, es);
    for (int j = 0; j < eb.size() && j < got_b.size(); j++) begin
      n_checks++;
      if (got_b[j] !== eb[j] || got_s[j] !== es[j]) begin
        n_fail++; $display("FAIL midrst_data j=%0d: got %b/%b, required %b/%b", j, got_b[j], got_s[j], eb[j], es[j]);
      end
    end
  endtask

  task automatic test_3x5_markers();
    bq_t eb, es;
    int t;
    int pos;
    clear_logs();
    b_out_ready = 1'b1;
    b_mode = 1'b0;
    for (int m = 0; m < N2; m++)
      for (int k = 0; k < N2; k++) begin
        b_in_bit   = (k == m);
        b_in_valid = 1'b1;
        t = 0;
        while (b_in_ready !== 1'b1 && t < 200) begin tick(); t++; end
        tick();
      end
    b_in_valid = 1'b0;
    t = 0;
    while (got2_b.size() < N2 * N2 && t < 500) begin tick(); t++; end
    n_checks++;
    if (got2_b.size() != N2 * N2) begin n_fail++; $display("FAIL m35_count: got %0d, required %0d", got2_b.size(), N2 * N2); end
    model(R2, C2, acc2_b, acc2_m, eb, es);
    for (int j = 0; j < eb.size() && j < got2_b.size(); j++) begin
      n_checks++;
      if (got2_b[j] !== eb[j] || got2_s[j] !== es[j]) begin
        n_fail++; $display("FAIL m35_data j=%0d: got %b/%b, required %b/%b", j, got2_b[j], got2_s[j], eb[j], es[j]);
      end
    end
    // Marker at stored bit 5 must come out at j=1; marker at 14 at j=14.
    if (got2_b.size() == N2 * N2) begin
      pos = -1;
      for (int j = 0; j < N2; j++) if (got2_b[5*N2 + j]) pos = j;
      n_checks++;
      if (pos != 1) begin n_fail++; $display("FAIL m35_marker5: got j=%0d, required 1", pos); end
      pos = -1;
      for (int j = 0; j < N2; j++) if (got2_b[14*N2 + j]) pos = j;
      n_checks++;
      if (pos != 14) begin n_fail++; $display("FAIL m35_marker14: got j=%0d, required 14", pos); end
    end
  endtask

`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
  task automatic test_frame_out();
    logic [7:0] src;
    src = 8'hB5;
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL fo_early: got %b, required 0", frame_valid); end
      end
      send_bit(src[k], 1'b0);
    end
    n_checks += 2;
    if (frame_valid !== 1'b1)  begin n_fail++; $display("FAIL fo_pulse: got %b, required 1", frame_valid); end
    if (frame_out !== 8'h9B)   begin n_fail++; $display("FAIL fo_value: got %h, required 9b", frame_out); end
    tick();
    n_checks += 2;
    if (frame_valid !== 1'b0)  begin n_fail++; $display("FAIL fo_pulse_end: got %b, required 0", frame_valid); end
    if (frame_out !== 8'h9B)   begin n_fail++; $display("FAIL fo_hold: got %h, required 9b", frame_out); end
    wait_outputs(8);
  endtask
`endif

  initial begin
    test_reset();
    test_b5();
    test_roundtrip();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_3x5_markers();
`ifdef BLOCK_INTERLEAVER_FRAME_OUT_EN
    test_frame_out();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
